// File: rtl/instruction_fetch_unit.sv
// Thumb instruction fetch unit: two-line (CUR/NEXT) word buffer with demand
// fetch and sequential prefetch over a single-outstanding memory read port.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter int WORD = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic [WORD-1:0] program_counter_i,
  input  logic            flush_i,
  output logic            mem_req_o,
  output logic [WORD-1:0] mem_addr_o,
  input  logic            mem_ack_i,
  input  logic [WORD-1:0] mem_rdata_i,
  output logic [15:0]     instr_o,
  output logic            instr_valid_o,
  output logic            fetch_stall_o
);

  localparam int TW = WORD - 2;

  typedef enum logic [1:0] {IDLE, FETCH, PREFETCH} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   req_tag_q, req_tag_d;
  logic            drop_q, drop_d;
  logic            cur_valid_q, cur_valid_d;
  logic [TW-1:0]   cur_tag_q, cur_tag_d;
  logic [WORD-1:0] cur_data_q, cur_data_d;
  logic            nxt_valid_q, nxt_valid_d;
  logic [TW-1:0]   nxt_tag_q, nxt_tag_d;
  logic [WORD-1:0] nxt_data_q, nxt_data_d;

  logic [TW-1:0]   pc_tag;
  logic [TW-1:0]   cur_tag_inc;
  logic            cur_hit, nxt_hit, nxt_is_seq, any_hit, accept;
  logic [WORD-1:0] hit_word;
  logic            unused_pc0;

  assign unused_pc0  = program_counter_i[0];
  assign pc_tag      = program_counter_i[WORD-1:2];
  assign cur_tag_inc = cur_tag_q + {{(TW-1){1'b0}}, 1'b1};
  assign cur_hit     = cur_valid_q && (cur_tag_q == pc_tag);
  assign nxt_hit     = !cur_hit && nxt_valid_q && (nxt_tag_q == pc_tag);
  assign nxt_is_seq  = nxt_valid_q && (nxt_tag_q == cur_tag_inc);
  assign accept      = (state_q != IDLE) && mem_ack_i;

  // Hits are masked during a redirect so the pipeline never sees a stale word.
  assign any_hit       = (cur_hit || nxt_hit) && !flush_i;
  assign hit_word      = cur_hit ? cur_data_q : nxt_data_q;
  assign instr_valid_o = any_hit;
  assign fetch_stall_o = !any_hit;
  assign instr_o       = !any_hit ? 16'h0000 :
                         (program_counter_i[1] ? hit_word[31:16] : hit_word[15:0]);
  assign mem_req_o     = (state_q != IDLE);
  assign mem_addr_o    = mem_req_o ? {req_tag_q, 2'b00} : '0;

  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    drop_d      = drop_q;
    cur_valid_d = cur_valid_q;
    cur_tag_d   = cur_tag_q;
    cur_data_d  = cur_data_q;
    nxt_valid_d = nxt_valid_q;
    nxt_tag_d   = nxt_tag_q;
    nxt_data_d  = nxt_data_q;

    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (!cur_hit && !nxt_hit) begin
            state_d   = FETCH;
            req_tag_d = pc_tag;
          end else if (cur_hit && !nxt_is_seq) begin
            state_d   = PREFETCH;
            req_tag_d = cur_tag_inc;
          end
        end
      end
      FETCH, PREFETCH: begin
        // A flush coinciding with the ack discards the word directly, so no drop flag is left behind.
        if (mem_ack_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (nxt_hit) begin
      cur_valid_d = 1'b1;
      cur_tag_d   = nxt_tag_q;
      cur_data_d  = nxt_data_q;
      nxt_valid_d = 1'b0;
    end

    if (accept && !drop_q && !flush_i) begin
      if (state_q == FETCH || req_tag_q == pc_tag) begin
        cur_valid_d = 1'b1;
        cur_tag_d   = req_tag_q;
        cur_data_d  = mem_rdata_i;
      end else begin
        nxt_valid_d = 1'b1;
        nxt_tag_d   = req_tag_q;
        nxt_data_d  = mem_rdata_i;
      end
    end

    if (flush_i) begin
      cur_valid_d = 1'b0;
      nxt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      req_tag_q   <= '0;
      drop_q      <= 1'b0;
      cur_valid_q <= 1'b0;
      cur_tag_q   <= '0;
      cur_data_q  <= '0;
      nxt_valid_q <= 1'b0;
      nxt_tag_q   <= '0;
      nxt_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      drop_q      <= drop_d;
      cur_valid_q <= cur_valid_d;
      cur_tag_q   <= cur_tag_d;
      cur_data_q  <= cur_data_d;
      nxt_valid_q <= nxt_valid_d;
      nxt_tag_q   <= nxt_tag_d;
      nxt_data_q  <= nxt_data_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed scenarios plus a random instruction stream checked against a
// versioned memory image (each flush models new code at the same addresses).
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        ack;
  logic [31:0] rdata;
  logic [15:0] instr;
  logic        ivalid;
  logic        stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.WORD(32)) dut (
    .clk_i             (clk),
    .reset_n_i         (reset_n),
    .program_counter_i (pc),
    .flush_i           (flush),
    .mem_req_o         (mem_req),
    .mem_addr_o        (mem_addr),
    .mem_ack_i         (ack),
    .mem_rdata_i       (rdata),
    .instr_o           (instr),
    .instr_valid_o     (ivalid),
    .fetch_stall_o     (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic f, input logic a, input logic [31:0] d);
    pc = p; flush = f; ack = a; rdata = d;
    #1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(32'h0, 1'b0, 1'b0, 32'h0);
    nxt(); nxt();
    reset_n = 1'b1;
  endtask

  // Memory image: word content depends on the address and the code version.
  function automatic logic [31:0] mw(input logic [31:0] a, input int v);
    return (a * 32'h9E3779B1) ^ (32'(v) * 32'h85EBCA6B) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] half_of(input logic [31:0] w, input logic [31:0] p);
    return p[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]};
  endfunction

  logic [31:0] rpc, raddr, rword, d;
  int          ver, lat, streak, r;
  bit          pend, fl, next_fl, a;

  initial begin
    reset_n = 1'b0;
    drive(32'h2, 1'b0, 1'b0, 32'h0);
    nxt(); nxt();
    chk("rst_req",   {31'h0, mem_req}, 32'h0);
    chk("rst_valid", {31'h0, ivalid},  32'h0);
    chk("rst_stall", {31'h0, stall},   32'h1);
    chk("rst_addr",  mem_addr,         32'h0);

    $display("scenario cold start");
    reset_n = 1'b1;
    drive(32'h2, 1'b0, 1'b0, 32'h0);
    chk("cold_idle_req", {31'h0, mem_req}, 32'h0);
    nxt();
    drive(32'h2, 1'b0, 1'b0, 32'h0);
    chk("cold_req",  {31'h0, mem_req}, 32'h1);
    chk("cold_addr", mem_addr, 32'h0);
    nxt(); drive(32'h2, 1'b0, 1'b0, 32'h0);
    nxt(); drive(32'h2, 1'b0, 1'b0, 32'h0);
    nxt(); drive(32'h2, 1'b0, 1'b1, 32'hBBBBAAAA);
    chk("cold_ackcyc_valid", {31'h0, ivalid}, 32'h0);
    nxt(); drive(32'h2, 1'b0, 1'b0, 32'h0);
    chk("cold_valid", {31'h0, ivalid}, 32'h1);
    chk("cold_instr", {16'h0, instr},  32'hBBBB);
    chk("cold_stall", {31'h0, stall},  32'h0);

    $display("scenario flush during prefetch");
    nxt(); drive(32'h2, 1'b1, 1'b0, 32'h0);
    chk("fl_valid", {31'h0, ivalid}, 32'h0);
    chk("fl_req",   {31'h0, mem_req}, 32'h1);
    chk("fl_addr",  mem_addr, 32'h4);
    nxt(); drive(32'h100, 1'b0, 1'b0, 32'h0);
    chk("fl_wait_req", {31'h0, mem_req}, 32'h1);
    nxt(); drive(32'h4, 1'b0, 1'b1, 32'hDEADBEEF);
    chk("fl_ack_valid", {31'h0, ivalid}, 32'h0);
    nxt(); drive(32'h100, 1'b0, 1'b0, 32'h0);
    chk("fl_after_valid", {31'h0, ivalid}, 32'h0);
    chk("fl_after_req",   {31'h0, mem_req}, 32'h0);
    nxt(); drive(32'h100, 1'b0, 1'b1, 32'h12345678);
    chk("fl_fetch_req",  {31'h0, mem_req}, 32'h1);
    chk("fl_fetch_addr", mem_addr, 32'h100);
    nxt(); drive(32'h100, 1'b0, 1'b0, 32'h0);
    chk("fl_new_valid", {31'h0, ivalid}, 32'h1);
    chk("fl_new_instr", {16'h0, instr},  32'h5678);

    $display("scenario sequential stream");
    do_reset();
    drive(32'h0, 1'b0, 1'b0, 32'h0); nxt();
    drive(32'h0, 1'b0, 1'b1, 32'h22221111);
    chk("seq_fetch_addr", mem_addr, 32'h0);
    chk("seq_fill_valid", {31'h0, ivalid}, 32'h0);
    nxt(); drive(32'h0, 1'b0, 1'b0, 32'h0);
    chk("seq_i0", {16'h0, instr}, 32'h1111);
    chk("seq_v0", {31'h0, ivalid}, 32'h1);
    chk("seq_idle_req", {31'h0, mem_req}, 32'h0);
    nxt(); drive(32'h2, 1'b0, 1'b1, 32'h44443333);
    chk("seq_pref_req",  {31'h0, mem_req}, 32'h1);
    chk("seq_pref_addr", mem_addr, 32'h4);
    chk("seq_i1", {16'h0, instr}, 32'h2222);
    chk("seq_v1", {31'h0, ivalid}, 32'h1);
    nxt(); drive(32'h4, 1'b0, 1'b0, 32'h0);
    chk("seq_i2", {16'h0, instr}, 32'h3333);
    chk("seq_v2", {31'h0, ivalid}, 32'h1);
    nxt(); drive(32'h6, 1'b0, 1'b0, 32'h0);
    chk("seq_i3", {16'h0, instr}, 32'h4444);
    chk("seq_v3", {31'h0, ivalid}, 32'h1);

    $display("scenario tag wrap");
    do_reset();
    drive(32'hFFFFFFFE, 1'b0, 1'b0, 32'h0); nxt();
    drive(32'hFFFFFFFE, 1'b0, 1'b1, 32'hCAFEF00D);
    chk("wrap_fetch_addr", mem_addr, 32'hFFFFFFFC);
    nxt(); drive(32'hFFFFFFFE, 1'b0, 1'b0, 32'h0);
    chk("wrap_instr", {16'h0, instr}, 32'hCAFE);
    nxt(); drive(32'hFFFFFFFE, 1'b0, 1'b1, 32'h0BAD1234);
    chk("wrap_pref_req",  {31'h0, mem_req}, 32'h1);
    chk("wrap_pref_addr", mem_addr, 32'h0);
    nxt(); drive(32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_next_valid", {31'h0, ivalid}, 32'h1);
    chk("wrap_next_instr", {16'h0, instr},  32'h1234);

    $display("scenario demand miss during prefetch");
    do_reset();
    drive(32'h0, 1'b0, 1'b0, 32'h0); nxt();
    drive(32'h0, 1'b0, 1'b1, 32'h10011000); nxt();
    drive(32'h0, 1'b0, 1'b0, 32'h0); nxt();
    drive(32'h2, 1'b0, 1'b1, 32'h30032002); nxt();
    drive(32'h4, 1'b0, 1'b0, 32'h0);
    chk("dm_v4", {31'h0, ivalid}, 32'h1);
    nxt(); drive(32'h4, 1'b0, 1'b0, 32'h0);
    chk("dm_i4", {16'h0, instr}, 32'h2002);
    nxt(); drive(32'h40, 1'b0, 1'b0, 32'h0);
    chk("dm_pref_addr", mem_addr, 32'h8);
    chk("dm_miss_valid0", {31'h0, ivalid}, 32'h0);
    nxt(); drive(32'h40, 1'b0, 1'b0, 32'h0);
    chk("dm_pref_hold", mem_addr, 32'h8);
    nxt(); drive(32'h40, 1'b0, 1'b1, 32'h50054004);
    chk("dm_miss_valid1", {31'h0, ivalid}, 32'h0);
    nxt(); drive(32'h40, 1'b0, 1'b0, 32'h0);
    chk("dm_gap_req", {31'h0, mem_req}, 32'h0);
    chk("dm_miss_valid2", {31'h0, ivalid}, 32'h0);
    nxt(); drive(32'h40, 1'b0, 1'b1, 32'h70076006);
    chk("dm_fetch_addr", mem_addr, 32'h40);
    chk("dm_miss_valid3", {31'h0, ivalid}, 32'h0);
    nxt(); drive(32'h40, 1'b0, 1'b0, 32'h0);
    chk("dm_i40", {16'h0, instr}, 32'h6006);
    nxt(); drive(32'h8, 1'b0, 1'b0, 32'h0);
    chk("dm_i8_valid", {31'h0, ivalid}, 32'h1);
    chk("dm_i8", {16'h0, instr}, 32'h4004);

    $display("scenario reset mid-fetch");
    do_reset();
    drive(32'h20, 1'b0, 1'b0, 32'h0); nxt();
    drive(32'h20, 1'b0, 1'b0, 32'h0);
    chk("rm_req", {31'h0, mem_req}, 32'h1);
    nxt();
    reset_n = 1'b0;
    drive(32'h20, 1'b0, 1'b0, 32'h0); nxt();
    reset_n = 1'b1;
    drive(32'h20, 1'b0, 1'b1, 32'hFFFFEEEE);
    chk("rm_idle_req", {31'h0, mem_req}, 32'h0);
    nxt(); drive(32'h20, 1'b0, 1'b0, 32'h0);
    chk("rm_ignored_valid", {31'h0, ivalid}, 32'h0);
    chk("rm_refetch_req",   {31'h0, mem_req}, 32'h1);
    chk("rm_refetch_addr",  mem_addr, 32'h20);
    nxt(); drive(32'h20, 1'b0, 1'b1, 32'h99998888);
    nxt(); drive(32'h20, 1'b0, 1'b0, 32'h0);
    chk("rm_valid", {16'h0, instr}, 32'h8888);

    $display("scenario random stream");
    do_reset();
    rpc = 32'h0; ver = 0; pend = 1'b0; lat = 0; streak = 0; next_fl = 1'b0;
    raddr = 32'h0; rword = 32'h0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      fl = next_fl;
      if (fl) ver++;
      a = 1'b0;
      d = $urandom;
      if (mem_req) begin
        if (!pend) begin
          pend  = 1'b1;
          raddr = mem_addr;
          rword = mw(mem_addr, ver);
          lat   = $urandom_range(0, 3);
        end else begin
          chk("r_addr_stable", mem_addr, raddr);
        end
        if (lat == 0) begin
          a = 1'b1; d = rword; pend = 1'b0;
          $display("txn addr=%h data=%h ver=%0d", raddr, rword, ver);
        end else begin
          lat--;
        end
      end else begin
        a = ($urandom_range(0, 4) == 0);
      end
      drive(rpc, fl, a, d);
      chk("r_stall", {31'h0, stall}, {31'h0, ~ivalid});
      chk("r_align", {30'h0, mem_addr[1:0]}, 32'h0);
      if (fl) chk("r_flush_valid", {31'h0, ivalid}, 32'h0);
      if (ivalid) chk("r_instr", {16'h0, instr}, half_of(mw({rpc[31:2], 2'b00}, ver), rpc));
      streak = ivalid ? 0 : streak + 1;
      chk("r_live", {31'h0, (streak > 16)}, 32'h0);
      next_fl = 1'b0;
      if (ivalid) begin
        r = $urandom_range(0, 19);
        if (r < 13)      rpc = rpc + 32'h2;
        else if (r < 15) begin rpc = {24'h0, 7'($urandom_range(0, 127)), 1'b0}; next_fl = 1'b1; end
        else if (r < 17) rpc = {24'h0, 7'($urandom_range(0, 127)), 1'b0};
      end
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
